exe_mem_req: RTL
================

Name: exe_mem_req

Overview:
EXE-stage memory-request unit sitting directly upstream of the MEM stage. It holds one instruction in a stage register and performs ALE checking. For loads and stores it drives the class-SRAM data request, holding the request until addr_ok. It forwards the instruction to MEM with a wait-for-data_ok flag, and discards data_ok responses that belong to instructions flushed by exceptions.

Parameters:
None (widths fixed by the data SRAM interface: 32-bit address/data, 4-bit strobe).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ds2es_valid  in  1  upstream instruction valid
es_allowin  out  1  stage can accept
ds_op_ld  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}, one-hot or zero
ds_op_st  in  3  {st_b, st_h, st_w}, one-hot or zero
ds_pc  in  32  instruction PC
ds_ex  in  1  upstream exception already pending
ds_vaddr  in  32  effective address from ALU
ds_st_data  in  32  store source register value
ms_allowin  in  1  MEM can accept
es2ms_valid  out  1  valid to MEM
es2ms_bus  out  41  {wait_data_ok, ld_zip[4:0], pc[31:0], ale, addr_lo[1:0]}
ms_ex  in  1  exception in MEM; suppresses new requests
wb_ex  in  1  flush from WB
data_sram_req  out  1  request
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  out  4  byte enables
data_sram_addr  out  32  byte address (not aligned down)
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response returned
discard_busy  out  1  a flushed request's data_ok is still outstanding

Behaviour:
- Handshake:
  - es_allowin = ~es_valid | (es_ready_go & ms_allowin).
  - es2ms_valid = es_valid & es_ready_go.
- Stage register:
  - es_valid <= 0 on reset or wb_ex.
  - Otherwise, when es_allowin, es_valid <= ds2es_valid.
  - Payload is latched when ds2es_valid & es_allowin.
- mem_op = |op_ld | |op_st.
- ale:
  - Set for half with addr[0] != 0.
  - Set for word with addr[1:0] != 0.
  - Clear for byte.
- ex_any = ds_ex(latched) | ale.
- need_req = es_valid & mem_op & ~ex_any & ~ms_ex & ~wb_ex.
- FSM, reset to IDLE:
  - IDLE: data_sram_req = need_req & ~discard_busy.
    - addr_ok & ms_allowin -> stay IDLE; the instruction advances this cycle.
    - addr_ok & ~ms_allowin -> ACC.
    - req with ~addr_ok -> HOLD.
  - HOLD: req = 1 unconditionally, with addr/size/wstrb/wdata/wr frozen; ms_ex and wb_ex do not drop it.
    - On addr_ok: if wb_ex in that cycle or earlier during HOLD (sticky flush flag) -> DISC.
    - Else if ms_allowin -> IDLE, else ACC.
  - ACC: req = 0; waits for ms_allowin -> IDLE. wb_ex -> DISC.
  - DISC: req = 0; discard_busy = 1; data_sram_data_ok -> IDLE.
    - A data_ok arriving in the same cycle as an addr_ok that enters DISC is not the flushed request's response.
- es_ready_go:
  - 1 if ~mem_op or ex_any or ms_ex.
  - Otherwise 1 in IDLE when addr_ok, and 1 in ACC.
  - 0 in HOLD without addr_ok, and 0 in DISC.
- wait_data_ok = mem_op & ~ex_any & request accepted. It is 0 for excepted instructions.
- ld_zip passes op_ld; addr_lo = vaddr[1:0].
- Store encoding:
  - st_b: wdata = {4{d[7:0]}}, wstrb = 1 << addr[1:0].
  - st_h: wdata = {2{d[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - st_w: wdata = d, wstrb = 4'b1111.
  - Loads: wstrb = 0, wr = 0.
- Reset values: es_valid = 0, es2ms_valid = 0, data_sram_req = 0, discard_busy = 0, FSM = IDLE, bus = 0.
- Simultaneous wb_ex and a new accept: flush wins; the stage is empty next cycle.

Test Plan:
- ld_w at 0x1000, addr_ok = 1, ms_allowin = 1 -> req with size = 2, wr = 0 for 1 cycle; es2ms_valid in the same cycle; bus wait_data_ok = 1, addr_lo = 0.
- st_b 0xAB at 0x2003, addr_ok delayed 3 cycles -> req held for 4 cycles with stable addr = 0x2003, wstrb = 4'b1000, wdata = 0xABABABAB; es_allowin = 0 until addr_ok.
- ld_h at 0x3001 -> no req; es2ms_valid next cycle with ale = 1, wait_data_ok = 0.
- st_w in HOLD, wb_ex pulses, addr_ok 2 cycles later -> req held through the flush; es_valid = 0; DISC with discard_busy = 1 until data_ok; a following ld_w sees req = 0 until the cycle after data_ok.
- addr_ok while ms_allowin = 0 -> ACC; no second req; advances when ms_allowin rises. A wb_ex asserted in ACC instead leads to DISC.
- resetn low mid-HOLD -> next cycle req = 0, es_valid = 0, discard_busy = 0.

Source files
------------

// File: rtl/exe_mem_req_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_mem_req_if
// Purpose  : Class-SRAM data-port bundle between the EXE request unit and memory.
// Revision : 1.0
// ============================================================================
interface exe_mem_req_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok
    );
endinterface
`default_nettype wire

// File: rtl/exe_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : exe_mem_req
// Purpose  : EXE-stage register with ALE check and class-SRAM request issue.
// Revision : 1.0
// ============================================================================
module exe_mem_req (
    input  wire                 clk,
    input  wire                 resetn,
    input  wire                 ds2es_valid,
    output logic                es_allowin,
    input  wire  [4:0]          ds_op_ld,
    input  wire  [2:0]          ds_op_st,
    input  wire  [31:0]         ds_pc,
    input  wire                 ds_ex,
    input  wire  [31:0]         ds_vaddr,
    input  wire  [31:0]         ds_st_data,
    input  wire                 ms_allowin,
    output logic                es2ms_valid,
    output logic [40:0]         es2ms_bus,
    input  wire                 ms_ex,
    input  wire                 wb_ex,
    exe_mem_req_if.master       sram,
    output logic                discard_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACC  = 2'd2,
        ST_DISC = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_es_valid;
    logic [4:0]  r_op_ld;
    logic [2:0]  r_op_st;
    logic [31:0] r_pc;
    logic        r_ex;
    logic [31:0] r_vaddr;
    logic [31:0] r_st_data;

    logic        r_flushed;
    logic        r_hold_wr;
    logic [1:0]  r_hold_size;
    logic [3:0]  r_hold_wstrb;
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_wdata;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_mem_op;
    logic        w_ale;
    logic        w_ex_any;
    logic        w_need_req;
    logic        w_req_idle;
    logic        w_flush_now;
    logic        w_accept;
    logic        w_ready_go;
    logic        w_wait_data_ok;
    logic        w_wr;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    assign w_is_half   = r_op_ld[2] | r_op_ld[1] | r_op_st[1];
    assign w_is_word   = r_op_ld[0] | r_op_st[0];
    assign w_mem_op    = (|r_op_ld) | (|r_op_st);
    assign w_ale       = (w_is_half & r_vaddr[0]) | (w_is_word & (|r_vaddr[1:0]));
    assign w_ex_any    = r_ex | w_ale;
    assign w_need_req  = r_es_valid & w_mem_op & ~w_ex_any & ~ms_ex & ~wb_ex;

    assign discard_busy = (r_state == ST_DISC);
    assign w_req_idle   = (r_state == ST_IDLE) & w_need_req & ~discard_busy;
    assign w_flush_now  = r_flushed | wb_ex;

    // An addr_ok seen in HOLD only belongs to the stage instruction if no flush intervened.
    assign w_accept = (w_req_idle & sram.data_sram_addr_ok)
                    | ((r_state == ST_HOLD) & sram.data_sram_addr_ok & ~w_flush_now)
                    | (r_state == ST_ACC);

    assign w_ready_go     = ~w_mem_op | w_ex_any | ms_ex | w_accept;
    assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
    assign es2ms_valid    = r_es_valid & w_ready_go;
    assign w_wait_data_ok = w_mem_op & ~w_ex_any & w_accept;
    assign es2ms_bus      = {w_wait_data_ok, r_op_ld, r_pc, w_ale, r_vaddr[1:0]};

    assign w_wr   = |r_op_st;
    assign w_size = w_is_word ? 2'd2 : (w_is_half ? 2'd1 : 2'd0);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = r_st_data;
        if (r_op_st[2]) begin
            w_wstrb = 4'b0001 << r_vaddr[1:0];
            w_wdata = {4{r_st_data[7:0]}};
        end else if (r_op_st[1]) begin
            w_wstrb = r_vaddr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_st_data[15:0]}};
        end else if (r_op_st[0]) begin
            w_wstrb = 4'b1111;
        end
    end

    // While holding, the stage register may already carry a younger instruction.
    assign sram.data_sram_req   = (r_state == ST_HOLD) | w_req_idle;
    assign sram.data_sram_wr    = (r_state == ST_HOLD) ? r_hold_wr    : w_wr;
    assign sram.data_sram_size  = (r_state == ST_HOLD) ? r_hold_size  : w_size;
    assign sram.data_sram_wstrb = (r_state == ST_HOLD) ? r_hold_wstrb : w_wstrb;
    assign sram.data_sram_addr  = (r_state == ST_HOLD) ? r_hold_addr  : r_vaddr;
    assign sram.data_sram_wdata = (r_state == ST_HOLD) ? r_hold_wdata : w_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_es_valid <= 1'b0;
            r_op_ld    <= 5'd0;
            r_op_st    <= 3'd0;
            r_pc       <= 32'd0;
            r_ex       <= 1'b0;
            r_vaddr    <= 32'd0;
            r_st_data  <= 32'd0;
        end else begin
            if (wb_ex) begin
                r_es_valid <= 1'b0;
            end else if (es_allowin) begin
                r_es_valid <= ds2es_valid;
            end
            if (ds2es_valid && es_allowin) begin
                r_op_ld   <= ds_op_ld;
                r_op_st   <= ds_op_st;
                r_pc      <= ds_pc;
                r_ex      <= ds_ex;
                r_vaddr   <= ds_vaddr;
                r_st_data <= ds_st_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_flushed    <= 1'b0;
            r_hold_wr    <= 1'b0;
            r_hold_size  <= 2'd0;
            r_hold_wstrb <= 4'd0;
            r_hold_addr  <= 32'd0;
            r_hold_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_idle) begin
                        if (sram.data_sram_addr_ok) begin
                            r_state <= ms_allowin ? ST_IDLE : ST_ACC;
                        end else begin
                            r_state      <= ST_HOLD;
                            r_flushed    <= 1'b0;
                            r_hold_wr    <= w_wr;
                            r_hold_size  <= w_size;
                            r_hold_wstrb <= w_wstrb;
                            r_hold_addr  <= r_vaddr;
                            r_hold_wdata <= w_wdata;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sram.data_sram_addr_ok) begin
                        if (w_flush_now) begin
                            r_state <= ST_DISC;
                        end else begin
                            r_state <= ms_allowin ? ST_IDLE : ST_ACC;
                        end
                    end else begin
                        // An owner that leaves early (via ms_ex) orphans the request like a flush.
                        r_flushed <= r_flushed | wb_ex | (es2ms_valid & ms_allowin);
                    end
                end
                ST_ACC: begin
                    if (wb_ex) begin
                        r_state <= ST_DISC;
                    end else if (ms_allowin) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DISC: begin
                    if (sram.data_sram_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
